// File: rtl/lcd_vga_pkg.sv
// Shared constants and helpers for the LCD capture / VGA scan-out block.
package lcd_vga_pkg;

  localparam int DEF_SRC_W      = 160;
  localparam int DEF_SRC_H      = 144;
  localparam int DEF_SCALE      = 4;
  localparam int DEF_H_FP       = 120;
  localparam int DEF_H_SYNC     = 128;
  localparam int DEF_H_BP       = 168;
  localparam int DEF_V_FP       = 13;
  localparam int DEF_V_SYNC     = 4;
  localparam int DEF_V_BP       = 35;
  localparam int DEF_FILTER_LEN = 3;
  localparam int DEF_COLOR_BITS = 2;
  localparam int DEF_TIMEOUT    = 2000000;

  // Grey ramp for 2-bit channels: index i shows level ~i on r, g and b.
  localparam logic [23:0] DEF_PALETTE = {6'b000000, 6'b010101, 6'b101010, 6'b111111};

  // Visible length of an upscaled axis (H_VIS / V_VIS).
  function automatic int vis_len(input int src, input int scale);
    return src * scale;
  endfunction

  // Total length of an axis including porches and sync (H_TOT / V_TOT).
  function automatic int tot_len(input int src, input int scale, input int fp,
                                 input int sync, input int bp);
    return src * scale + fp + sync + bp;
  endfunction

  // LSB position of palette entry idx inside the packed palette bus.
  function automatic int pal_lsb(input int idx, input int cb);
    return idx * 3 * cb;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Glitch filter for one asynchronous input: the filtered state only changes
// after FILTER_LEN consecutive equal samples; rise/fall pulse for one cycle
// together with the state change.
module sync_filter
  import lcd_vga_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);

  logic [FILTER_LEN-1:0] samples;
  logic                  all_high;
  logic                  all_low;

  assign all_high = &samples;
  assign all_low  = ~|samples;

  // Shift in the raw pin and flip the state once every sample agrees.
  always_ff @(posedge clk) begin
    if (reset) begin
      samples <= '0;
      state   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      samples <= {samples[FILTER_LEN-2:0], raw};
      rise    <= all_high && !state;
      fall    <= all_low && state;
      if (all_high)
        state <= 1'b1;
      else if (all_low)
        state <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_capture_vga.sv
// Captures a filtered 2-bpp LCD stream into an external framebuffer by x/y
// and scans it out as integer-scaled VGA through a 4-entry palette; shows
// colour bars while the input has no vsync.
module lcd_capture_vga
  import lcd_vga_pkg::*;
#(
  parameter int SRC_W      = DEF_SRC_W,
  parameter int SRC_H      = DEF_SRC_H,
  parameter int SCALE      = DEF_SCALE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int FB_AW      = $clog2(SRC_W * SRC_H)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lcd_clk,
  input  logic                    lcd_hsync,
  input  logic                    lcd_vsync,
  input  logic [1:0]              lcd_data,
  input  logic [12*COLOR_BITS-1:0] palette,
  output logic                    fb_wr_en,
  output logic [FB_AW-1:0]        fb_wr_addr,
  output logic [1:0]              fb_wr_data,
  output logic [FB_AW-1:0]        fb_rd_addr,
  input  logic [1:0]              fb_rd_data,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    signal_lost
);

  localparam int H_VIS = vis_len(SRC_W, SCALE);
  localparam int V_VIS = vis_len(SRC_H, SCALE);
  localparam int H_TOT = tot_len(SRC_W, SCALE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = tot_len(SRC_H, SCALE, V_FP, V_SYNC, V_BP);
  localparam int SHIFT = $clog2(SCALE);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int XW    = $clog2(SRC_W + 1);
  localparam int YW    = $clog2(SRC_H + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int CB3   = 3 * COLOR_BITS;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS_C    = HW'(H_VIS);
  localparam logic [VW-1:0] V_VIS_C    = VW'(V_VIS);
  localparam logic [HW-1:0] H_HS_START = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] H_HS_END   = HW'(H_VIS + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_VS_START = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] V_VS_END   = VW'(V_VIS + V_FP + V_SYNC);
  localparam logic [HW-1:0] BAR1       = HW'(H_VIS / 4);
  localparam logic [HW-1:0] BAR2       = HW'(2 * (H_VIS / 4));
  localparam logic [HW-1:0] BAR3       = HW'(3 * (H_VIS / 4));

  // ---------------- input filtering ----------------
  logic vs_state, vs_rise, vs_fall;
  logic hs_state, hs_rise, hs_fall;
  logic ck_state, ck_rise, ck_fall;
  logic unused_filter;

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_vs_filter (
    .clk(clk), .reset(reset), .raw(lcd_vsync),
    .state(vs_state), .rise(vs_rise), .fall(vs_fall));
  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_hs_filter (
    .clk(clk), .reset(reset), .raw(lcd_hsync),
    .state(hs_state), .rise(hs_rise), .fall(hs_fall));
  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_ck_filter (
    .clk(clk), .reset(reset), .raw(lcd_clk),
    .state(ck_state), .rise(ck_rise), .fall(ck_fall));

  assign unused_filter = ^{vs_state, vs_fall, hs_state, hs_rise, ck_state, ck_rise};

  // ---------------- capture ----------------
  logic [XW-1:0]    x, x_nxt;
  logic [YW-1:0]    y, y_nxt;
  logic             pix_ok;
  logic [FB_AW-1:0] pix_addr;

  // Apply vsync, then hsync, then the pixel, so a pixel coinciding with a
  // sync lands on the freshly updated position.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (vs_rise) begin
      x_nxt = '0;
      y_nxt = '0;
    end
    if (hs_fall && x_nxt != '0) begin
      x_nxt = '0;
      if (y_nxt != YW'(SRC_H))
        y_nxt = y_nxt + YW'(1);
    end
    pix_ok   = ck_fall && (x_nxt < XW'(SRC_W)) && (y_nxt < YW'(SRC_H));
    pix_addr = FB_AW'(y_nxt) * FB_AW'(SRC_W) + FB_AW'(x_nxt);
    if (ck_fall && x_nxt != XW'(SRC_W))
      x_nxt = x_nxt + XW'(1);
  end

  // Position registers and the one-cycle framebuffer write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      fb_wr_en   <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
    end else begin
      x        <= x_nxt;
      y        <= y_nxt;
      fb_wr_en <= pix_ok;
      if (pix_ok) begin
        fb_wr_addr <= pix_addr;
        fb_wr_data <= lcd_data;
      end
    end
  end

  // ---------------- input-loss timer ----------------
  logic [TW-1:0] to_cnt;

  // Down-counter armed by each input vsync; hitting zero flags signal loss.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      signal_lost <= 1'b1;
    end else if (vs_rise) begin
      to_cnt      <= TW'(TIMEOUT);
      signal_lost <= 1'b0;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
      if (to_cnt == TW'(1))
        signal_lost <= 1'b1;
    end
  end

  // ---------------- VGA timing (k0) ----------------
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          visible, hs_act, vs_act;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign visible    = (h < H_VIS_C) && (v < V_VIS_C);
  assign hs_act     = (h >= H_HS_START) && (h < H_HS_END);
  assign vs_act     = (v >= V_VS_START) && (v < V_VS_END);
  assign fb_rd_addr = visible ? FB_AW'(v >> SHIFT) * FB_AW'(SRC_W) + FB_AW'(h >> SHIFT) : '0;

  // ---------------- k1: RAM data arrives ----------------
  logic [HW-1:0] h_k1;
  logic          vis_k1, hs_k1, vs_k1;

  // Delay raster state by one cycle to line up with fb_rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_k1   <= '0;
      vis_k1 <= 1'b0;
      hs_k1  <= 1'b0;
      vs_k1  <= 1'b0;
    end else begin
      h_k1   <= h;
      vis_k1 <= visible;
      hs_k1  <= hs_act;
      vs_k1  <= vs_act;
    end
  end

  // ---------------- k2: palette lookup ----------------
  logic [CB3-1:0] pal_entry [4];
  logic [1:0]     idx;
  logic [CB3-1:0] entry;

  for (genvar i = 0; i < 4; i++) begin : g_pal
    assign pal_entry[i] = palette[pal_lsb(i, COLOR_BITS) +: CB3];
  end

  // Colour-bar index replaces framebuffer data while the input is lost.
  always_comb begin
    idx = fb_rd_data;
    if (signal_lost) begin
      if (h_k1 >= BAR3)
        idx = 2'd3;
      else if (h_k1 >= BAR2)
        idx = 2'd2;
      else if (h_k1 >= BAR1)
        idx = 2'd1;
      else
        idx = 2'd0;
    end
    entry = pal_entry[idx];
  end

  // Registered VGA outputs, blanked outside the visible window.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_hsync <= hs_k1 ? HSYNC_POL : ~HSYNC_POL;
      vga_vsync <= vs_k1 ? VSYNC_POL : ~VSYNC_POL;
      vga_r     <= vis_k1 ? entry[CB3-1 -: COLOR_BITS] : '0;
      vga_g     <= vis_k1 ? entry[2*COLOR_BITS-1 -: COLOR_BITS] : '0;
      vga_b     <= vis_k1 ? entry[COLOR_BITS-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_lcd_capture_vga.sv
// Directed bench for lcd_capture_vga with default parameters.
module tb_lcd_capture_vga;

  localparam int HT = 1056;  // 640 + 120 + 128 + 168

  localparam logic [5:0] E0 = 6'b000110;
  localparam logic [5:0] E1 = 6'b111001;
  localparam logic [5:0] E2 = 6'b011011;
  localparam logic [5:0] E3 = 6'b100001;

  logic        clk = 1'b0;
  logic        reset;
  logic        lcd_clk, lcd_hsync, lcd_vsync;
  logic [1:0]  lcd_data;
  logic [23:0] palette;
  logic        fb_wr_en;
  logic [14:0] fb_wr_addr;
  logic [1:0]  fb_wr_data;
  logic [14:0] fb_rd_addr;
  logic [1:0]  fb_rd_data;
  logic        vga_hsync, vga_vsync;
  logic [1:0]  vga_r, vga_g, vga_b;
  logic        signal_lost;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [1:0] mem [0:23039];
  int q_addr[$];
  int q_data[$];

  lcd_capture_vga dut (
    .clk(clk), .reset(reset),
    .lcd_clk(lcd_clk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_data(lcd_data),
    .palette(palette),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .signal_lost(signal_lost));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // External RAM: one-cycle read latency.
  always @(posedge clk) fb_rd_data <= mem[fb_rd_addr];

  // Write log.
  always @(negedge clk) begin
    if (!reset && fb_wr_en) begin
      q_addr.push_back(int'(fb_wr_addr));
      q_data.push_back(int'(fb_wr_data));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pixel(input logic [1:0] d);
    lcd_clk = 1'b1;
    tick(3);
    lcd_data = d;
    lcd_clk = 1'b0;
    tick(5);
  endtask

  task automatic hsync_pulse();
    lcd_hsync = 1'b1;
    tick(3);
    lcd_hsync = 1'b0;
    tick(5);
  endtask

  function automatic logic [5:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  initial begin
    int bad;
    for (int i = 0; i < 23040; i++) mem[i] = 2'd0;
    reset = 1'b1;
    lcd_clk = 1'b0; lcd_hsync = 1'b0; lcd_vsync = 1'b0; lcd_data = 2'd0;
    palette = {E3, E2, E1, E0};
    tick(3);

    // Reset state
    chk("rst_hsync", vga_hsync, 0);
    chk("rst_vsync", vga_vsync, 0);
    chk("rst_rgb", rgb(), 0);
    chk("rst_wr_en", fb_wr_en, 0);
    chk("rst_lost", signal_lost, 1);
    chk("rst_rd_addr", fb_rd_addr, 0);
    reset = 1'b0;

    // Test 1: colour bars on line 0, hsync window
    wait_cyc(2);    chk("bar_h0", rgb(), E0);
    chk("lost_init", signal_lost, 1);
    wait_cyc(5);    chk("rd_addr_h5", fb_rd_addr, 1);
    wait_cyc(161);  chk("bar_h159", rgb(), E0);
    wait_cyc(162);  chk("bar_h160", rgb(), E1);
    wait_cyc(481);  chk("bar_h479", rgb(), E2);
    wait_cyc(482);  chk("bar_h480", rgb(), E3);
    wait_cyc(641);  chk("bar_h639", rgb(), E3);
    wait_cyc(642);  chk("blank_h640", rgb(), 0);
    wait_cyc(700);  chk("rd_addr_blank", fb_rd_addr, 0);
    wait_cyc(761);  chk("hs_h759", vga_hsync, 0);
    wait_cyc(762);  chk("hs_h760", vga_hsync, 1);
    wait_cyc(889);  chk("hs_h887", vga_hsync, 1);
    wait_cyc(890);  chk("hs_h888", vga_hsync, 0);
    chk("vs_line0", vga_vsync, 0);

    // Test 2: vsync, then 160 pixels on line 0
    lcd_vsync = 1'b1;
    tick(6);
    chk("lost_after_vs", signal_lost, 0);
    for (int i = 0; i < 160; i++) pixel(2'(i % 4));
    tick(2);
    chk("line0_writes", q_addr.size(), 160);
    bad = 0;
    for (int i = 0; i < 160 && i < q_addr.size(); i++)
      if (q_addr[i] != i || q_data[i] != i % 4) bad++;
    chk("line0_content_bad", bad, 0);

    // Test 4a: 10 extra pixels on line 0 are dropped
    for (int i = 0; i < 10; i++) pixel(2'd1);
    tick(2);
    chk("line0_saturate", q_addr.size(), 160);

    // Test 3: 2-cycle glitch ignored, 3-cycle pulse writes once at line 1
    hsync_pulse();
    lcd_clk = 1'b1;
    tick(2);
    lcd_clk = 1'b0;
    tick(8);
    chk("glitch_no_write", q_addr.size(), 160);
    pixel(2'd3);
    tick(2);
    chk("line1_count", q_addr.size(), 161);
    chk("line1_addr", (q_addr.size() > 160) ? q_addr[160] : -1, 160);
    chk("line1_data", (q_data.size() > 160) ? q_data[160] : -1, 3);

    // Test 4b: lines 2..142 one pixel each, line 143 full plus extras
    for (int ln = 2; ln < 143; ln++) begin
      hsync_pulse();
      pixel(2'(ln % 4));
    end
    tick(2);
    chk("line142_count", q_addr.size(), 302);
    chk("line142_addr", (q_addr.size() > 301) ? q_addr[301] : -1, 22720);
    hsync_pulse();
    for (int i = 0; i < 170; i++) pixel(2'(i % 4));
    tick(2);
    chk("line143_count", q_addr.size(), 462);
    chk("line143_first", (q_addr.size() > 302) ? q_addr[302] : -1, 22880);
    chk("line143_last", (q_addr.size() > 461) ? q_addr[461] : -1, 23039);
    chk("line143_last_data", (q_data.size() > 461) ? q_data[461] : -1, 3);
    for (int ln = 144; ln < 150; ln++) begin
      hsync_pulse();
      pixel(2'd2);
    end
    tick(2);
    chk("beyond_frame", q_addr.size(), 462);

    // Test 5: vsync rise coincident with a pixel fall
    lcd_vsync = 1'b0;
    tick(6);
    lcd_clk = 1'b1;
    tick(3);
    lcd_vsync = 1'b1;
    lcd_clk = 1'b0;
    lcd_data = 2'd2;
    tick(5);
    tick(2);
    chk("coinc_count", q_addr.size(), 463);
    chk("coinc_addr", (q_addr.size() > 462) ? q_addr[462] : -1, 0);
    chk("coinc_data", (q_data.size() > 462) ? q_data[462] : -1, 2);
    pixel(2'd1);
    tick(2);
    chk("after_coinc_addr", (q_addr.size() > 463) ? q_addr[463] : -1, 1);
    chk("after_coinc_data", (q_data.size() > 463) ? q_data[463] : -1, 1);
    chk("lost_still_low", signal_lost, 0);

    // Test 6: mid-frame reset, then framebuffer scan-out
    reset = 1'b1;
    tick(1);
    chk("mid_rst_rgb", rgb(), 0);
    chk("mid_rst_hsync", vga_hsync, 0);
    chk("mid_rst_lost", signal_lost, 1);
    chk("mid_rst_wr_en", fb_wr_en, 0);
    chk("mid_rst_rd_addr", fb_rd_addr, 0);
    for (int i = 0; i < 23040; i++) mem[i] = 2'd0;
    mem[161] = 2'd2;
    tick(2);
    reset = 1'b0;
    // lcd_vsync is still high: the cleared filter sees a fresh rise
    wait_cyc(10);            chk("lost_relock", signal_lost, 0);
    wait_cyc(3 * HT + 6);    chk("v3_h4", rgb(), E0);
    wait_cyc(4 * HT + 4);    chk("rd_addr_v4_h4", fb_rd_addr, 161);
    wait_cyc(4 * HT + 5);    chk("v4_h3", rgb(), E0);
    wait_cyc(4 * HT + 6);    chk("v4_h4", rgb(), E2);
    wait_cyc(4 * HT + 9);    chk("v4_h7", rgb(), E2);
    wait_cyc(4 * HT + 10);   chk("v4_h8", rgb(), E0);
    wait_cyc(4 * HT + 702);  chk("v4_blank", rgb(), 0);
    wait_cyc(4 * HT + 762);  chk("v4_hs_h760", vga_hsync, 1);
    wait_cyc(7 * HT + 7);    chk("v7_h5", rgb(), E2);
    wait_cyc(8 * HT + 6);    chk("v8_h4", rgb(), E0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_capture_vga.md
Name: lcd_capture_vga

Overview:
Parametrised successor to the handheld-LCD-to-VGA converter. Captures a 2-bit-per-pixel LCD stream (pixel clock, hsync and vsync, all asynchronous and glitch-filtered) into an external dual-port framebuffer, addressing pixels by explicit x/y.
Scans the framebuffer out as integer-scaled VGA through a 4-entry programmable palette. When no input frames arrive, it shows a colour-bar test pattern.
Sits between the LCD connector pins and the board VGA DAC. The PLL and framebuffer RAM stay external.

Parameters:
SRC_W, 160, source pixels per line
SRC_H, 144, source lines per frame
SCALE, 4, integer upscale; power of two, 1..8
H_FP/H_SYNC/H_BP, 120/128/168, horizontal porch and sync widths in clk cycles
V_FP/V_SYNC/V_BP, 13/4/35, vertical porch and sync widths in lines
HSYNC_POL/VSYNC_POL, 1/1, active level of the VGA syncs
FILTER_LEN, 3, number of consecutive equal samples needed to change a filtered input state (>=2)
COLOR_BITS, 2, bits per RGB channel
TIMEOUT, 2000000, clk cycles without an input vsync before signal_lost is set
FB_AW, $clog2(SRC_W*SRC_H), framebuffer address width

Ports:
clk  in  1  pixel clock (PLL output)
reset  in  1  synchronous, active-high
lcd_clk  in  1  raw LCD pixel clock (async)
lcd_hsync  in  1  raw LCD line sync (async)
lcd_vsync  in  1  raw LCD frame sync (async)
lcd_data  in  2  raw LCD pixel value
palette  in  12*COLOR_BITS  entry i = bits [i*3*CB +: 3*CB] as {r,g,b}; quasi-static
fb_wr_en  out  1  one-cycle write strobe
fb_wr_addr  out  FB_AW  write address
fb_wr_data  out  2  write data
fb_rd_addr  out  FB_AW  read address; RAM returns q one clk later
fb_rd_data  in  2  read data
vga_hsync  out  1  horizontal sync
vga_vsync  out  1  vertical sync
vga_r/vga_g/vga_b  out  COLOR_BITS each  colour outputs
signal_lost  out  1  high when no input vsync has arrived within TIMEOUT

Behaviour:
- Reset values:
  - all counters 0; fb_wr_en 0; fb_wr_addr/fb_wr_data 0.
  - VGA syncs at inactive level (~POL); rgb 0.
  - signal_lost 1; filtered states 0.
- Input filter:
  - each raw input is shifted into a FILTER_LEN-deep sample register.
  - when all samples agree and differ from the filtered state, the state flips.
  - a rise or fall pulse is asserted for exactly that cycle.
  - lcd_data is sampled in the cycle the lcd_clk fall pulse occurs.
- Capture counters: x in 0..SRC_W, y in 0..SRC_H, both saturating. Per cycle, applied in this order:
  1. vsync rise: x=0, y=0; timeout counter cleared; signal_lost <= 0.
  2. hsync fall, if x!=0: x=0, y=min(y+1,SRC_H).
  3. lcd_clk fall: if x<SRC_W and y<SRC_H, then next cycle fb_wr_en=1, fb_wr_addr=y*SRC_W+x, fb_wr_data=sampled data. x=min(x+1,SRC_W).
- Coincident input events: a sync coinciding with a pixel fall is applied first, and the pixel uses the updated x/y (vsync+pixel writes address 0, then x=1).
- Out-of-range pixels are dropped. Extra lines or pixels never wrap into other addresses.
- Timeout: a counter increments every cycle, saturating at TIMEOUT. On reaching TIMEOUT, signal_lost <= 1.
- Output timing:
  - h counter 0..H_TOT-1, with H_VIS=SRC_W*SCALE and H_TOT=H_VIS+H_FP+H_SYNC+H_BP.
  - v counter increments when h wraps, over 0..V_TOT-1, with V_VIS=SRC_H*SCALE.
  - visible = h<H_VIS && v<V_VIS.
  - hsync active for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; vsync uses the same rule on v.
- Read address: stage k0 drives fb_rd_addr = visible ? (v>>log2 SCALE)*SRC_W + (h>>log2 SCALE) : 0.
- Output pipeline:
  - fb_rd_data is valid at k1.
  - at k2, index = signal_lost ? (h_k1 / (H_VIS/4)) clamped to 3 : fb_rd_data.
  - vga_r/g/b, registered at k2, = palette[index] when visible, else 0.
  - syncs are delayed the same 2 registers, so every VGA output has 2-cycle latency from its counter value.
- Reset mid-frame: all state returns to reset values within 1 cycle. The next frame starts at h=v=0.

Decomposition:
- Package lcd_vga_pkg holds:
  - default timing constants and the derived H_TOT/V_TOT/H_VIS/V_VIS functions;
  - the palette entry slice helper;
  - the default palette (index i -> level ~i, grey).
- Sub-module sync_filter (parameter FILTER_LEN; outputs state, rise, fall), instantiated three times.

Test Plan:
1. Reset released, no input -> signal_lost=1. Visible line 0 shows palette[0],[1],[2],[3] bars, each 160 clk wide (defaults). vga_hsync active for h 760..887, seen 2 cycles late.
2. vsync rise, then 160 clean lcd_clk falls with data i%4 -> 160 fb writes at addresses 0..159, data i%4. signal_lost becomes 0.
3. lcd_clk glitch lasting 2 clk cycles (FILTER_LEN=3) -> no write and x unchanged. A 3-cycle pulse -> exactly one write.
4. 170 pixel falls on one line -> exactly 160 writes. hsync fall -> next write address 160. 150 lines -> last write address 23039, nothing beyond.
5. vsync rise coincident with a pixel fall -> write to address 0, then the next pixel goes to address 1.
6. Framebuffer preloaded addr 161 = 2, palette[2] = {2'b01,2'b10,2'b11} -> pixels h=4..7 on lines v=4..7 output rgb 01/10/11 two cycles after h is driven. Blanking outputs 0.
